lector_contadores: RTL

// - Read sequencer directly downstream of the per-FIFO word counters.
// - On a start command it sweeps the four counters while the link FSM reports IDLE.
// - For each counter it drives req/idx, captures contador_out at fixed latency, then commits all four values together.
// - Output holds a coherent snapshot of all four counts for the probador/scoreboard.

---
 rtl/lector_contadores.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lector_contadores.sv
// Sweeps the four per-FIFO word counters and commits a coherent snapshot of them.
// Optional feature: define LECTOR_TOTAL_EN to add the registered 'total' port (sum of the snapshot).
module lector_contadores #(
  parameter int CNT_WIDTH = 5,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IDLE,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] contador_in,
  input  logic                 valid_contador,
  output logic                 req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3,
  output logic                 busy,
  output logic                 done,
  output logic                 error
`ifdef LECTOR_TOTAL_EN
  ,
  output logic [CNT_WIDTH+1:0] total
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_DONE} state_t;

  state_t               state, state_next;
  logic [IDX_WIDTH-1:0] k;
  logic [CNT_WIDTH-1:0] shadow [4];
  logic                 accept, abort, capture, last, commit;

`ifdef LECTOR_TOTAL_EN
  function automatic logic [CNT_WIDTH+1:0] sum4(input logic [CNT_WIDTH-1:0] a,
                                                input logic [CNT_WIDTH-1:0] b,
                                                input logic [CNT_WIDTH-1:0] c,
                                                input logic [CNT_WIDTH-1:0] d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = S_REQ;
      S_REQ:   state_next = abort ? S_IDLE : S_CAP;
      S_CAP: begin
        if (abort)     state_next = S_IDLE;
        else if (last) state_next = S_DONE;
        else           state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Losing IDLE or valid_contador anywhere in the read phase abandons the sweep.
  always_comb begin
    accept  = 1'b0;
    abort   = 1'b0;
    capture = 1'b0;
    last    = (k == IDX_WIDTH'(3));
    unique case (state)
      S_IDLE: accept = start && IDLE;
      S_REQ:  abort  = !IDLE;
      S_CAP: begin
        abort   = !IDLE || !valid_contador;
        capture = IDLE && valid_contador;
      end
      default: ;
    endcase
    commit = capture && last;
  end

  // The last count is taken straight from contador_in so the snapshot lands in the S_DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k      <= '0;
      req    <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
      cnt2   <= '0;
      cnt3   <= '0;
      shadow <= '{default: '0};
`ifdef LECTOR_TOTAL_EN
      total  <= '0;
`endif
    end else begin
      req  <= (state_next == S_REQ);
      done <= (state_next == S_DONE);
      if (accept) begin
        k     <= '0;
        idx   <= '0;
        busy  <= 1'b1;
        error <= 1'b0;
      end
      if (abort) begin
        busy  <= 1'b0;
        error <= 1'b1;
      end
      if (capture) begin
        shadow[k[1:0]] <= contador_in;
        if (!last) begin
          k   <= k + IDX_WIDTH'(1);
          idx <= k + IDX_WIDTH'(1);
        end
      end
      if (commit) begin
        cnt0 <= shadow[0];
        cnt1 <= shadow[1];
        cnt2 <= shadow[2];
        cnt3 <= contador_in;
        busy <= 1'b0;
`ifdef LECTOR_TOTAL_EN
        total <= sum4(shadow[0], shadow[1], shadow[2], contador_in);
`endif
      end
    end
  end

endmodule
